// File: rtl/shift32_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// shift32_seq_ctrl_if
//   Command channel into the 32-bit shift register sequencer: one command is
//   transferred per cycle where cmd_valid and cmd_ready are both high.
//
//   Signals
//     cmd_valid  master->slave  command request
//     cmd_ready  slave->master  sequencer can take a command this cycle
//     cmd_op     master->slave  00 CLR, 01 LOAD, 10 SHL, 11 SHR
//     cmd_cnt    master->slave  shift count (SHL/SHR only, saturates at 32)
//     cmd_data   master->slave  parallel word (LOAD only)
//     cmd_fill   master->slave  serial fill bit (SHL/SHR only)
//
//   Modports: master (command source), slave (sequencer)
// -----------------------------------------------------------------------------
interface shift32_seq_ctrl_if #(
    parameter int CNT_W = 6
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic [31:0]      cmd_data;
    logic             cmd_fill;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_cnt,
        output cmd_data,
        output cmd_fill,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_cnt,
        input  cmd_data,
        input  cmd_fill,
        output cmd_ready
    );
endinterface

// File: rtl/shift32_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift32_seq_ctrl
//   Sequencer for a 32-bit universal shift register built from eight chained
//   74LS194 slices. Takes one command at a time, drives the mode bits, clear,
//   parallel data and serial fill, counts shift cycles and pulses done.
//
//   Ports
//     clk       in   system clock, rising edge
//     clear_n   in   synchronous active-low reset
//     cmd       slave modport of shift32_seq_ctrl_if (valid/ready command)
//     q         in   shift register Q feedback (used only for rotate)
//     S1, S0    out  mode: 00 hold, 10 left, 01 right, 11 load
//     sh_clear  out  active-high clear to the shift register
//     pdata     out  parallel load data
//     SL, SR    out  serial fill into Q[0] (left) / Q[31] (right)
//     busy      out  high from the cycle after accept through the done cycle
//     done      out  one-cycle completion pulse
//     cnt_rem   out  shift cycles remaining
//
//   Configuration
//     SHIFT32_ROTATE_EN  when defined, shift fill comes from Q feedback
//                        (SL=q[31], SR=q[0]) so shifts become rotates.
// -----------------------------------------------------------------------------
module shift32_seq_ctrl #(
    parameter int CNT_W = 6
) (
    input  logic                clk,
    input  logic                clear_n,
    shift32_seq_ctrl_if.slave   cmd,
    input  logic [31:0]         q,
    output logic                S1,
    output logic                S0,
    output logic                sh_clear,
    output logic [31:0]         pdata,
    output logic                SL,
    output logic                SR,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    cnt_rem
);

    localparam logic [CNT_W-1:0] MAX_SHIFT = CNT_W'(32);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             shift_left;
    logic             shift_left_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_sat;
    logic [31:0]      pdata_nxt;
    logic             accept;

    assign cmd.cmd_ready = clear_n && (state == ST_IDLE);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign cnt_sat       = (cmd.cmd_cnt > MAX_SHIFT) ? MAX_SHIFT : cmd.cmd_cnt;

    // Next-state and captured command fields. All registered outputs are
    // derived from the next state so they line up with the state they belong to.
    always_comb begin
        state_nxt      = state;
        shift_left_nxt = shift_left;
        cnt_nxt        = cnt_rem;
        pdata_nxt      = pdata;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd.cmd_op)
                        2'b00: state_nxt = ST_CLR;
                        2'b01: begin
                            state_nxt = ST_LOAD;
                            pdata_nxt = cmd.cmd_data;
                        end
                        default: begin
                            shift_left_nxt = (cmd.cmd_op == 2'b10);
                            cnt_nxt        = cnt_sat;
                            // A zero count skips the shift state entirely.
                            state_nxt      = (cnt_sat == '0) ? ST_DONE : ST_SHIFT;
                        end
                    endcase
                end
            end
            ST_CLR, ST_LOAD: state_nxt = ST_DONE;
            ST_SHIFT: begin
                cnt_nxt = cnt_rem - CNT_W'(1);
                if (cnt_rem == CNT_W'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any operation with S=00.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state      <= ST_IDLE;
            shift_left <= 1'b0;
            cnt_rem    <= '0;
            pdata      <= '0;
            S1         <= 1'b0;
            S0         <= 1'b0;
            sh_clear   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift_left <= shift_left_nxt;
            cnt_rem    <= cnt_nxt;
            pdata      <= pdata_nxt;
            S1         <= (state_nxt == ST_LOAD) || ((state_nxt == ST_SHIFT) && shift_left_nxt);
            S0         <= (state_nxt == ST_LOAD) || ((state_nxt == ST_SHIFT) && !shift_left_nxt);
            sh_clear   <= (state_nxt == ST_CLR);
            busy       <= (state_nxt != ST_IDLE);
            done       <= (state_nxt == ST_DONE);
        end
    end

`ifdef SHIFT32_ROTATE_EN
    // Rotate: the bit leaving one end is fed straight back into the other.
    logic fill_unused;
    assign fill_unused = cmd.cmd_fill;
    assign SL = (state == ST_SHIFT) && shift_left && q[31];
    assign SR = (state == ST_SHIFT) && !shift_left && q[0];
`else
    logic q_unused;
    assign q_unused = ^q;

    // Fill bit is captured at accept and held for the whole shift run; only
    // the line matching the shift direction carries it.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            SL <= 1'b0;
            SR <= 1'b0;
        end else if (state_nxt == ST_SHIFT) begin
            if (state == ST_IDLE) begin
                SL <= cmd.cmd_fill && shift_left_nxt;
                SR <= cmd.cmd_fill && !shift_left_nxt;
            end
        end else begin
            SL <= 1'b0;
            SR <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_shift32_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift32_seq_ctrl
//   Self-checking bench for shift32_seq_ctrl. A behavioural 74LS194 chain
//   closes the loop on q; directed command vectors with hand-computed results
//   are applied from a table, then the busy-ignore and reset-abort sequences
//   are exercised by hand. Rotate expectations apply when SHIFT32_ROTATE_EN
//   is defined.
// -----------------------------------------------------------------------------
module tb_shift32_seq_ctrl;

    localparam int CNT_W = 6;

    logic             clk;
    logic             clear_n;
    logic [31:0]      q;
    logic             S1, S0, sh_clear, SL, SR, busy, done;
    logic [31:0]      pdata;
    logic [CNT_W-1:0] cnt_rem;
    logic             preset_en;
    logic [31:0]      preset_val;

    int checks_total;
    int checks_passed;

    shift32_seq_ctrl_if #(.CNT_W(CNT_W)) cmd_bus ();

    shift32_seq_ctrl #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .clear_n  (clear_n),
        .cmd      (cmd_bus),
        .q        (q),
        .S1       (S1),
        .S0       (S0),
        .sh_clear (sh_clear),
        .pdata    (pdata),
        .SL       (SL),
        .SR       (SR),
        .busy     (busy),
        .done     (done),
        .cnt_rem  (cnt_rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural shift register: clear wins, then mode select. The bench can
    // preset it directly so each vector starts from a known word.
    always @(posedge clk) begin
        if (preset_en)
            q <= preset_val;
        else if (sh_clear)
            q <= 32'h0;
        else begin
            case ({S1, S0})
                2'b10:   q <= {q[30:0], SL};
                2'b01:   q <= {SR, q[31:1]};
                2'b11:   q <= pdata;
                default: q <= q;
            endcase
        end
    end

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  cnt;
        logic [31:0] data;
        logic        fill;
        logic [31:0] init_q;
        logic [31:0] exp_q_plain;
        logic [31:0] exp_q_rot;
        int          exp_lat;
        int          exp_act;
        int          exp_cnt1;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [1:0] op, input logic [5:0] cnt,
                                input logic [31:0] data, input logic fill,
                                input logic [31:0] init_q, input logic [31:0] eq_plain,
                                input logic [31:0] eq_rot, input int lat,
                                input int act, input int cnt1);
        vec_t v;
        v.op = op; v.cnt = cnt; v.data = data; v.fill = fill; v.init_q = init_q;
        v.exp_q_plain = eq_plain; v.exp_q_rot = eq_rot;
        v.exp_lat = lat; v.exp_act = act; v.exp_cnt1 = cnt1;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks_total++;
        if (actual === expected)
            checks_passed++;
        else
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    endtask

    task automatic preset_q(input logic [31:0] val);
        @(negedge clk);
        preset_val = val;
        preset_en  = 1'b1;
        @(negedge clk);
        preset_en  = 1'b0;
    endtask

    task automatic drive_cmd(input logic [1:0] op, input logic [5:0] cnt,
                             input logic [31:0] data, input logic fill);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = op;
        cmd_bus.cmd_cnt   = cnt;
        cmd_bus.cmd_data  = data;
        cmd_bus.cmd_fill  = fill;
    endtask

    // Runs one table vector: latency, active mode cycles, busy cycles, fill
    // lines, cnt_rem and the resulting register word.
    task automatic apply_stimulus(input int idx, input vec_t v);
        int lat, act, bcnt, ferr;
        logic [CNT_W-1:0] cnt1;
        logic [31:0] exp_q;
        string tag;
        tag = $sformatf("v%0d", idx);
`ifdef SHIFT32_ROTATE_EN
        exp_q = v.exp_q_rot;
`else
        exp_q = v.exp_q_plain;
`endif
        preset_q(v.init_q);
        drive_cmd(v.op, v.cnt, v.data, v.fill);
        check_output({tag, "_ready_idle"}, {31'h0, cmd_bus.cmd_ready}, 32'h1);
        @(negedge clk);
        cmd_bus.cmd_valid = 1'b0;
        lat = 0; act = 0; bcnt = 0; ferr = 0; cnt1 = '0;
        for (int k = 1; k <= 100; k++) begin
            if (k == 1) cnt1 = cnt_rem;
            if (busy) bcnt++;
            if (S1 || S0 || sh_clear) act++;
`ifdef SHIFT32_ROTATE_EN
            if (S1 && !S0 && (SL !== q[31] || SR !== 1'b0)) ferr++;
            if (!S1 && S0 && (SR !== q[0] || SL !== 1'b0)) ferr++;
`else
            if (S1 && !S0 && (SL !== v.fill || SR !== 1'b0)) ferr++;
            if (!S1 && S0 && (SR !== v.fill || SL !== 1'b0)) ferr++;
`endif
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check_output({tag, "_latency"}, lat, v.exp_lat);
        check_output({tag, "_active_cycles"}, act, v.exp_act);
        check_output({tag, "_busy_cycles"}, bcnt, v.exp_lat);
        check_output({tag, "_fill_errors"}, ferr, 0);
        check_output({tag, "_q"}, q, exp_q);
        if (v.exp_cnt1 >= 0) begin
            check_output({tag, "_cnt_first"}, {26'h0, cnt1}, v.exp_cnt1);
            check_output({tag, "_cnt_at_done"}, {26'h0, cnt_rem}, 0);
        end
        @(negedge clk);
        check_output({tag, "_ready_after"}, {30'h0, cmd_bus.cmd_ready, done}, 32'h2);
    endtask

    initial begin
        int lat, rdy_cnt, done_cnt;
        checks_total  = 0;
        checks_passed = 0;
        clear_n       = 1'b0;
        preset_en     = 1'b0;
        preset_val    = 32'h0;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op    = 2'b00;
        cmd_bus.cmd_cnt   = '0;
        cmd_bus.cmd_data  = 32'h0;
        cmd_bus.cmd_fill  = 1'b0;

        //               op     cnt  data          fill  init_q        plain         rotate        lat act cnt1
        vecs[0]  = mk(2'b01,  0, 32'hDEADBEEF, 1'b0, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF,  2,  1, -1);
        vecs[1]  = mk(2'b10,  4, 32'h0,        1'b1, 32'h00000001, 32'h0000001F, 32'h00000010,  5,  4,  4);
        vecs[2]  = mk(2'b11, 40, 32'h0,        1'b0, 32'h80000000, 32'h00000000, 32'h80000000, 33, 32, 32);
        vecs[3]  = mk(2'b10,  0, 32'h0,        1'b1, 32'h12345678, 32'h12345678, 32'h12345678,  1,  0,  0);
        vecs[4]  = mk(2'b00,  7, 32'h0,        1'b0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000,  2,  1, -1);
        vecs[5]  = mk(2'b11,  4, 32'h0,        1'b1, 32'h0000F000, 32'hF0000F00, 32'h00000F00,  5,  4,  4);
        vecs[6]  = mk(2'b10, 32, 32'h0,        1'b0, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 33, 32, 32);
        vecs[7]  = mk(2'b10,  1, 32'h0,        1'b0, 32'h80000001, 32'h00000002, 32'h00000003,  2,  1,  1);
        vecs[8]  = mk(2'b01, 63, 32'h0F0F0F0F, 1'b1, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0F0F,  2,  1, -1);
        vecs[9]  = mk(2'b11, 33, 32'h0,        1'b1, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 33, 32, 32);
        vecs[10] = mk(2'b10,  8, 32'h0,        1'b0, 32'h12345678, 32'h34567800, 32'h34567812,  9,  8,  8);
        vecs[11] = mk(2'b11, 32, 32'h0,        1'b1, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 33, 32, 32);

        // Reset state
        preset_q(32'h0);
        @(negedge clk);
        check_output("reset_ctrl", {24'h0, S1, S0, sh_clear, SL, SR, busy, done, cmd_bus.cmd_ready}, 32'h0);
        check_output("reset_pdata", pdata, 32'h0);
        check_output("reset_cnt_rem", {26'h0, cnt_rem}, 32'h0);
        clear_n = 1'b1;
        @(negedge clk);
        check_output("ready_after_reset", {31'h0, cmd_bus.cmd_ready}, 32'h1);

        for (int i = 0; i < NV; i++) begin
            apply_stimulus(i, vecs[i]);
        end

        // cmd_valid held through a busy operation must not start a second one.
        preset_q(32'h00000001);
        drive_cmd(2'b10, 6'd3, 32'h0, 1'b0);
        @(negedge clk);
        drive_cmd(2'b01, 6'd0, 32'hAAAA5555, 1'b0);
        lat = 0; rdy_cnt = 0;
        for (int k = 1; k <= 50; k++) begin
            if (cmd_bus.cmd_ready) rdy_cnt++;
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        cmd_bus.cmd_valid = 1'b0;
        check_output("busy_ignore_latency", lat, 4);
        check_output("busy_ignore_ready", rdy_cnt, 0);
        check_output("busy_ignore_q", q, 32'h00000008);
        repeat (3) @(negedge clk);
        check_output("busy_ignore_q_held", q, 32'h00000008);
        check_output("busy_ignore_idle", {30'h0, busy, done}, 32'h0);

        // Reset mid-shift: SHR 8, clear_n low so it takes effect at the third shift edge.
        preset_q(32'hFF000000);
        drive_cmd(2'b11, 6'd8, 32'h0, 1'b0);
        @(negedge clk);
        cmd_bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clear_n = 1'b0;
        @(negedge clk);
        check_output("abort_mode", {30'h0, S1, S0}, 32'h0);
        check_output("abort_flags", {29'h0, busy, done, cmd_bus.cmd_ready}, 32'h0);
        check_output("abort_cnt_rem", {26'h0, cnt_rem}, 32'h0);
        check_output("abort_q", q, 32'h1FE00000);
        clear_n = 1'b1;
        #1;
        check_output("abort_ready_release", {31'h0, cmd_bus.cmd_ready}, 32'h1);
        done_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check_output("abort_no_done", done_cnt, 0);
        check_output("abort_q_held", q, 32'h1FE00000);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    // Hard stop in case a wait above ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
